freq_synth: RTL and testbench

Programmable square-wave source that produces a signal at an exact decimal frequency entered as four BCD digits, optionally scaled ×10. It drives the frequency meter's input path and replaces the fixed four-frequency test generator. Frequencies from 0 to 99 990 Hz are generated from the 50 MHz system clock with a phase accumulator that is exact on average and has no division.

---
 rtl/freq_synth_pkg.sv | 28 ++
 rtl/freq_nco.sv | 62 ++++++
 rtl/freq_synth.sv | 125 ++++++++++++
 tb/tb_freq_synth.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/freq_synth_pkg.sv
// ============================================================================
// Module   : freq_synth_pkg
// Purpose  : Shared constants, FSM encoding and x10 helper for freq_synth.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package freq_synth_pkg;

    localparam int unsigned CLK_HZ_DEFAULT = 50_000_000;
    localparam int          DIGIT_W        = 4;
    localparam int          FREQ_W         = 17;
    localparam int          VAL_W          = 14;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_CONV  = 2'd1,
        ST_APPLY = 2'd2
    } state_t;

    // Multiply by ten using two shifts and an add; no multiplier inferred.
    function automatic logic [FREQ_W-1:0] times10(input logic [FREQ_W-1:0] x);
        return (x << 3) + (x << 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/freq_nco.sv
// ============================================================================
// Module   : freq_nco
// Purpose  : Modulo-HALF phase accumulator producing a square wave and rise pulse.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_nco
    import freq_synth_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
    parameter int unsigned ACC_W  = 26
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FREQ_W-1:0] i_inc,
    input  logic              i_restart,
    output logic              o_sigout,
    output logic              o_rise
);

    localparam logic [ACC_W-1:0] c_HALF = ACC_W'(CLK_HZ / 2);

    logic [ACC_W-1:0] r_acc;
    logic             r_sig;
    logic             r_rise;
    logic [ACC_W-1:0] w_sum;
    logic             w_wrap;

    // acc < HALF and inc <= 99 990, so the sum never overflows ACC_W bits.
    assign w_sum  = r_acc + ACC_W'(i_inc);
    assign w_wrap = (w_sum >= c_HALF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc  <= '0;
            r_sig  <= 1'b0;
            r_rise <= 1'b0;
        end else if (i_restart) begin
            r_acc  <= '0;
            r_sig  <= 1'b0;
            r_rise <= 1'b0;
        end else if (i_inc != '0) begin
            r_rise <= w_wrap & ~r_sig;
            if (w_wrap) begin
                r_acc <= w_sum - c_HALF;
                r_sig <= ~r_sig;
            end else begin
                r_acc <= w_sum;
            end
        end else begin
            r_sig  <= 1'b0;
            r_rise <= 1'b0;
        end
    end

    assign o_sigout = r_sig;
    assign o_rise   = r_rise;

endmodule

`default_nettype wire

// File: rtl/freq_synth.sv
// ============================================================================
// Module   : freq_synth
// Purpose  : BCD-programmed square-wave synthesiser (0..99 990 Hz) driving freq_nco.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module freq_synth
    import freq_synth_pkg::*;
#(
    parameter int unsigned CLK_HZ = CLK_HZ_DEFAULT,
    parameter int unsigned ACC_W  = 26
) (
    input  logic               sysclk,
    input  logic               reset,
    input  logic               load,
    input  logic [DIGIT_W-1:0] d4,
    input  logic [DIGIT_W-1:0] d3,
    input  logic [DIGIT_W-1:0] d2,
    input  logic [DIGIT_W-1:0] d1,
    input  logic               range_x10,
    output logic               busy,
    output logic               set_err,
    output logic [FREQ_W-1:0]  freq_bin,
    output logic               sigout,
    output logic               rise
);

    state_t                   r_state;
    state_t                   w_state_next;
    logic [1:0]               r_step;
    logic [4*DIGIT_W-1:0]     r_digits;
    logic                     r_x10;
    logic [VAL_W-1:0]         r_v;
    logic                     r_err;
    logic                     r_busy;
    logic                     r_set_err;
    logic [FREQ_W-1:0]        r_freq;

    logic [DIGIT_W-1:0]       w_digit;
    logic                     w_digit_bad;
    logic [VAL_W-1:0]         w_v_next;
    logic [FREQ_W-1:0]        w_scaled;
    logic                     w_restart;

    // Digits are shifted out MSB-first so the converter always sees d4 first.
    assign w_digit     = r_digits[4*DIGIT_W-1 -: DIGIT_W];
    assign w_digit_bad = (w_digit > 4'd9);
    assign w_v_next    = VAL_W'(times10(FREQ_W'(r_v)) + FREQ_W'(w_digit));
    assign w_scaled    = r_x10 ? times10(FREQ_W'(r_v)) : FREQ_W'(r_v);
    assign w_restart   = (r_state == ST_APPLY) && !r_err;

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_RUN:   if (load) w_state_next = ST_CONV;
            ST_CONV:  if (r_step == 2'd3) w_state_next = ST_APPLY;
            ST_APPLY: w_state_next = ST_RUN;
            default:  w_state_next = ST_RUN;
        endcase
    end

    always_ff @(posedge sysclk) begin
        if (reset) begin
            r_state   <= ST_RUN;
            r_step    <= '0;
            r_digits  <= '0;
            r_x10     <= 1'b0;
            r_v       <= '0;
            r_err     <= 1'b0;
            r_busy    <= 1'b0;
            r_set_err <= 1'b0;
            r_freq    <= '0;
        end else begin
            r_state <= w_state_next;
            r_busy  <= (w_state_next != ST_RUN);
            case (r_state)
                ST_RUN: begin
                    if (load) begin
                        r_digits  <= {d4, d3, d2, d1};
                        r_x10     <= range_x10;
                        r_v       <= '0;
                        r_err     <= 1'b0;
                        r_set_err <= 1'b0;
                        r_step    <= '0;
                    end
                end
                ST_CONV: begin
                    r_v      <= w_v_next;
                    r_err    <= r_err | w_digit_bad;
                    r_digits <= {r_digits[3*DIGIT_W-1:0], {DIGIT_W{1'b0}}};
                    r_step   <= r_step + 2'd1;
                end
                ST_APPLY: begin
                    // A bad setting leaves the running frequency and phase untouched.
                    if (r_err) begin
                        r_set_err <= 1'b1;
                    end else begin
                        r_freq <= w_scaled;
                    end
                end
                default: ;
            endcase
        end
    end

    freq_nco #(
        .CLK_HZ (CLK_HZ),
        .ACC_W  (ACC_W)
    ) u_nco (
        .clk       (sysclk),
        .rst       (reset),
        .i_inc     (r_freq),
        .i_restart (w_restart),
        .o_sigout  (sigout),
        .o_rise    (rise)
    );

    assign busy     = r_busy;
    assign set_err  = r_set_err;
    assign freq_bin = r_freq;

endmodule

`default_nettype wire

// File: tb/tb_freq_synth.sv
// ============================================================================
// Module   : tb_freq_synth
// Purpose  : Scoreboard bench: arithmetic reference model vs freq_synth outputs.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_freq_synth;

    localparam longint unsigned HALF_A = 64'd25_000_000;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Main DUT at 50 MHz
    logic        rst_a, load_a, x10_a;
    logic [3:0]  da4, da3, da2, da1;
    logic        busy_a, err_a, sig_a, rise_a;
    logic [16:0] fb_a;

    // Small DUT at 1 kHz for the exact-count window test
    logic        rst_b, load_b, x10_b;
    logic [3:0]  db4, db3, db2, db1;
    logic        busy_b, err_b, sig_b, rise_b;
    logic [16:0] fb_b;

    freq_synth u_dut_a (
        .sysclk(clk), .reset(rst_a), .load(load_a),
        .d4(da4), .d3(da3), .d2(da2), .d1(da1), .range_x10(x10_a),
        .busy(busy_a), .set_err(err_a), .freq_bin(fb_a), .sigout(sig_a), .rise(rise_a)
    );

    freq_synth #(.CLK_HZ(1000), .ACC_W(17)) u_dut_b (
        .sysclk(clk), .reset(rst_b), .load(load_b),
        .d4(db4), .d3(db3), .d2(db2), .d1(db1), .range_x10(x10_b),
        .busy(busy_b), .set_err(err_b), .freq_bin(fb_b), .sigout(sig_b), .rise(rise_b)
    );

    int          checks   = 0;
    int          failures = 0;
    int unsigned ec       = 0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, ec);
        end
    endtask

    typedef struct { int unsigned cyc; bit level; } edge_t;
    typedef struct { int unsigned start; int unsigned fall; int unsigned freq; bit err; } res_t;
    edge_t edge_q[$];
    res_t  res_q[$];

    // Reference model: frequency from digit arithmetic, waveform from
    // toggles = floor(n*f/HALF) where n counts accumulate cycles since restart.
    bit               m_busy  = 0;
    int unsigned      m_start = 0;
    int unsigned      m_val   = 0;
    bit               m_bad   = 0;
    int unsigned      m_f     = 0;
    longint unsigned  m_n     = 0;
    bit               m_err   = 0;
    bit               m_level = 0;

    always @(posedge clk) begin : p_model
        longint unsigned q;
        bit new_level;
        ec++;
        if (rst_a) begin
            if (m_busy) res_q.push_back('{m_start, ec, 0, 1'b0});
            m_busy = 0; m_f = 0; m_n = 0; m_err = 0;
        end else if (m_busy && ec == m_start + 5) begin
            m_busy = 0;
            if (m_bad) begin
                m_err = 1;
                if (m_f != 0) m_n++;
            end else begin
                m_err = 0;
                m_f   = m_val;
                m_n   = 0;
            end
            res_q.push_back('{m_start, ec, m_f, m_err});
        end else begin
            if (m_f != 0) m_n++;
            if (!m_busy && load_a) begin
                m_busy  = 1;
                m_start = ec;
                m_bad   = (da4 > 9) || (da3 > 9) || (da2 > 9) || (da1 > 9);
                m_val   = 1000 * int'(da4) + 100 * int'(da3) + 10 * int'(da2) + int'(da1);
                if (x10_a) m_val = m_val * 10;
            end
        end
        q = (m_n * longint'(m_f)) / HALF_A;
        new_level = (m_f == 0) ? 1'b0 : q[0];
        if (new_level != m_level) edge_q.push_back('{ec, new_level});
        m_level = new_level;
    end

    bit          p_sig = 0;
    bit          p_busy = 0;
    int unsigned busy_rise_cyc = 0;

    always @(negedge clk) begin : p_monitor
        edge_t e;
        res_t  r;
        while (edge_q.size() > 0 && edge_q[0].cyc < ec) begin
            e = edge_q.pop_front();
            chk("sig_edge_missed_cycle", longint'(ec), longint'(e.cyc));
        end
        if (sig_a !== p_sig || rise_a !== 1'b0) begin
            if (edge_q.size() == 0) begin
                chk("sigout_unexpected_change", longint'(sig_a), longint'(p_sig));
                chk("rise_unexpected", longint'(rise_a), 0);
            end else begin
                e = edge_q.pop_front();
                chk("sig_edge_cycle", longint'(ec), longint'(e.cyc));
                chk("sig_edge_level", longint'(sig_a), longint'(e.level));
                chk("rise_at_edge", longint'(rise_a), longint'(e.level));
            end
        end
        while (res_q.size() > 0 && res_q[0].fall < ec) begin
            r = res_q.pop_front();
            chk("busy_fall_missed_cycle", longint'(ec), longint'(r.fall));
        end
        if (busy_a === 1'b1 && !p_busy) begin
            busy_rise_cyc = ec;
            chk("set_err_cleared_on_accept", longint'(err_a), 0);
        end
        if (busy_a !== 1'b1 && p_busy) begin
            if (res_q.size() == 0) begin
                chk("busy_unexpected_fall", longint'(busy_a), longint'(p_busy));
            end else begin
                r = res_q.pop_front();
                chk("busy_start_cycle", longint'(busy_rise_cyc), longint'(r.start));
                chk("busy_fall_cycle", longint'(ec), longint'(r.fall));
                chk("freq_bin", longint'(fb_a), longint'(r.freq));
                chk("set_err", longint'(err_a), longint'(r.err));
            end
        end
        p_sig  = (sig_a === 1'b1);
        p_busy = (busy_a === 1'b1);
    end

    task automatic do_load(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] c, input logic [3:0] d, input logic x);
        da4 = a; da3 = b; da2 = c; da1 = d; x10_a = x; load_a = 1'b1;
        @(negedge clk);
        load_a = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_busy"},    longint'(busy_a), 0);
        chk({tag, "_set_err"}, longint'(err_a),  0);
        chk({tag, "_freq_bin"},longint'(fb_a),   0);
        chk({tag, "_sigout"},  longint'(sig_a),  0);
        chk({tag, "_rise"},    longint'(rise_a), 0);
    endtask

    initial begin : p_stim_a
        logic [3:0] d [4];
        rst_a = 1'b1; load_a = 1'b0; x10_a = 1'b0;
        da4 = '0; da3 = '0; da2 = '0; da1 = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst_a = 1'b0;
        repeat (1000) @(negedge clk);
        chk_all_zero("idle");

        do_load(4'd3, 4'd1, 4'd2, 4'd5, 1'b0);          // 3125 Hz
        repeat (5 + 3 * 8000 + 100) @(negedge clk);

        do_load(4'd3, 4'hA, 4'd2, 4'd5, 1'b0);          // bad digit while running
        repeat (6000) @(negedge clk);

        do_load(4'd2, 4'd0, 4'd0, 4'd0, 1'b0);          // clears set_err
        repeat (2) @(negedge clk);
        do_load(4'd9, 4'd9, 4'd9, 4'd9, 1'b1);          // lands at T+3: dropped
        repeat (3000) @(negedge clk);

        do_load(4'd1, 4'd2, 4'd5, 4'd0, 1'b1);          // 12 500 Hz
        repeat (6100) @(negedge clk);

        do_load(4'd4, 4'd0, 4'd0, 4'd0, 1'b0);
        repeat (5) @(negedge clk);
        do_load(4'd5, 4'd0, 4'd0, 4'd0, 1'b0);          // lands at T+6: accepted
        repeat (3000) @(negedge clk);

        do_load(4'd8, 4'd0, 4'd0, 4'd0, 1'b0);
        @(negedge clk);
        rst_a = 1'b1;                                    // reset during conversion
        @(negedge clk);
        rst_a = 1'b0;
        chk_all_zero("abort");
        repeat (20) @(negedge clk);
        chk("abort_no_apply_freq_bin", longint'(fb_a), 0);

        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 4; j++) d[j] = 4'($urandom_range(0, 9));
            if ($urandom_range(0, 5) == 0) d[$urandom_range(0, 3)] = 4'($urandom_range(10, 15));
            do_load(d[0], d[1], d[2], d[3], 1'($urandom_range(0, 1)));
            repeat ($urandom_range(1500, 3000)) @(negedge clk);
        end

        @(negedge clk);
        #1;
        chk("pending_sig_edges", longint'(edge_q.size()), 0);
        chk("pending_results", longint'(res_q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // 1 kHz instance: 7 Hz must give exactly 14 toggles and 7 rises in any
    // 1000-cycle window, with half-periods of 71 or 72 cycles.
    initial begin : p_stim_b
        int tog, rises, last_i, hp;
        bit prev, have_last;
        rst_b = 1'b1; load_b = 1'b0; x10_b = 1'b0;
        db4 = '0; db3 = '0; db2 = '0; db1 = '0;
        repeat (3) @(negedge clk);
        rst_b = 1'b0;
        db1 = 4'd7; load_b = 1'b1;
        @(negedge clk);
        load_b = 1'b0;
        repeat (5) @(negedge clk);
        chk("b_busy_done", longint'(busy_b), 0);
        chk("b_freq_bin", longint'(fb_b), 7);
        chk("b_set_err", longint'(err_b), 0);
        repeat (50) @(negedge clk);
        prev = sig_b; tog = 0; rises = 0; have_last = 0; last_i = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (rise_b) rises++;
            if (sig_b != prev) begin
                tog++;
                if (have_last) begin
                    hp = i - last_i;
                    chk("b_half_period", longint'(hp), (hp < 72) ? 71 : 72);
                end
                have_last = 1;
                last_i = i;
            end
            prev = sig_b;
        end
        chk("b_toggles_per_1000", longint'(tog), 14);
        chk("b_rises_per_1000", longint'(rises), 7);
    end

endmodule

`default_nettype wire
